filt_scratch_loader: RTL and testbench

Parametrised successor to the single-filter buffer reader. Drains filter coefficients from the filter input FIFO (first-word-fall-through) into the filter scratchpad, packing as many whole filters of length `filt_len` as fit in `SCRATCH_DEPTH`, or stopping early at a programmable filter count. It reports how many filters were loaded, flags illegal lengths, and emits a one-cycle done pulse. It sits between the filter FIFO and the filter scratchpad write port, under the PE top-level controller.

---
 rtl/filt_load_pkg.sv | 19 +
 rtl/filt_load_addr_gen.sv | 71 +++++++
 rtl/filt_scratch_loader.sv | 113 +++++++++++
 tb/tb_filt_scratch_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_load_pkg.sv
// rtl/filt_load_pkg.sv - shared state encoding and width helpers for the filter scratchpad loader
package filt_load_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        LOAD = 3'd2,
        PAD  = 3'd3,
        DONE = 3'd4
    } filt_state_e;

    // Fit checks add address, one and filter length; two extra bits keep the sum from wrapping.
    function automatic int fit_w(input int addr_len);
        return addr_len + 2;
    endfunction

endpackage

// File: rtl/filt_load_addr_gen.sv
// rtl/filt_load_addr_gen.sv - address, element and filter counters with the load terminate check
module filt_load_addr_gen
    import filt_load_pkg::*;
#(
    parameter int ADDR_LEN      = 5,
    parameter int SCRATCH_DEPTH = 32,
    parameter int MAX_FILT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic                  pad_en,
    input  logic [ADDR_LEN-1:0]   len_in,
    input  logic [MAX_FILT_W-1:0] max_in,
    output logic [ADDR_LEN-1:0]   addr,
    output logic [MAX_FILT_W-1:0] count,
    output logic                  terminate,
    output logic                  addr_last
);

    localparam int FW = fit_w(ADDR_LEN);
    localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(SCRATCH_DEPTH - 1);

    logic [ADDR_LEN-1:0]   len_q;
    logic [ADDR_LEN-1:0]   elem;
    logic [MAX_FILT_W-1:0] max_q;
    logic [MAX_FILT_W-1:0] count_inc;
    logic                  filt_end;
    logic                  hit_limit;
    logic                  no_fit;

    assign addr_last = (addr == LAST_ADDR);

    // A filter completes on the write of its last coefficient.
    assign filt_end  = wr_en && (({2'b00, elem} + FW'(1)) == {2'b00, len_q});
    assign count_inc = (&count) ? count : count + MAX_FILT_W'(1);

    // Stop at the programmed limit, at a saturated count, or when another filter would not fit.
    assign hit_limit = ((max_q != '0) && (count_inc == max_q)) || (&count_inc);
    assign no_fit    = ({2'b00, addr} + FW'(1) + {2'b00, len_q}) > FW'(SCRATCH_DEPTH);
    assign terminate = filt_end && (hit_limit || no_fit);

    // Counters clear and the load parameters latch while the FSM sits in INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            elem  <= '0;
            count <= '0;
            len_q <= '0;
            max_q <= '0;
        end else if (clear) begin
            addr  <= '0;
            elem  <= '0;
            count <= '0;
            len_q <= len_in;
            max_q <= max_in;
        end else begin
            if ((wr_en || pad_en) && !addr_last) begin
                addr <= addr + ADDR_LEN'(1);
            end
            if (wr_en) begin
                elem <= filt_end ? '0 : elem + ADDR_LEN'(1);
            end
            if (filt_end) begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/filt_scratch_loader.sv
// rtl/filt_scratch_loader.sv - drains whole filters from the filter FIFO into the scratchpad; FILT_LOAD_ZERO_PAD_EN enables zero padding
module filt_scratch_loader
    import filt_load_pkg::*;
#(
    parameter int ADDR_LEN      = 5,
    parameter int SCRATCH_DEPTH = 32,
    parameter int SCRATCH_WIDTH = 8,
    parameter int MAX_FILT_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_LEN-1:0]      filt_len,
    input  logic [MAX_FILT_W-1:0]    max_filt,
    input  logic                     filt_buf_empty,
    input  logic [SCRATCH_WIDTH-1:0] filt_buf_rdata,
    output logic                     filt_buf_read,
    output logic                     filt_scratch_wen,
    output logic [ADDR_LEN-1:0]      filt_waddr,
    output logic [SCRATCH_WIDTH-1:0] filt_wdata,
    output logic                     filt_ready,
    output logic                     filt_done,
    output logic [MAX_FILT_W-1:0]    filt_count,
    output logic                     filt_err
);

`ifdef FILT_LOAD_ZERO_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int FW = fit_w(ADDR_LEN);

    filt_state_e         state;
    filt_state_e         state_nxt;
    logic                len_bad;
    logic                load_wr;
    logic                pad_wr;
    logic                terminate;
    logic                addr_last;
    logic [ADDR_LEN-1:0] addr;

    assign len_bad = (filt_len == '0) || ({2'b00, filt_len} > FW'(SCRATCH_DEPTH));
    assign load_wr = (state == LOAD) && !filt_buf_empty;
    assign pad_wr  = PAD_EN && (state == PAD);

    filt_load_addr_gen #(
        .ADDR_LEN     (ADDR_LEN),
        .SCRATCH_DEPTH(SCRATCH_DEPTH),
        .MAX_FILT_W   (MAX_FILT_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == INIT),
        .wr_en    (load_wr),
        .pad_en   (pad_wr),
        .len_in   (filt_len),
        .max_in   (max_filt),
        .addr     (addr),
        .count    (filt_count),
        .terminate(terminate),
        .addr_last(addr_last)
    );

    // Next-state decode; start overrides every state and restarts the load.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = IDLE;
            INIT: state_nxt = len_bad ? DONE : LOAD;
            LOAD: begin
                if (terminate) begin
                    state_nxt = (PAD_EN && !addr_last) ? PAD : DONE;
                end
            end
            PAD:  state_nxt = addr_last ? DONE : PAD;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = INIT;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Illegal-length flag: cleared by start, decided in INIT, sticky until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_err <= 1'b0;
        end else if (start) begin
            filt_err <= 1'b0;
        end else if (state == INIT) begin
            filt_err <= len_bad;
        end
    end

    assign filt_buf_read    = load_wr;
    assign filt_scratch_wen = load_wr || pad_wr;
    assign filt_waddr       = addr;
    assign filt_wdata       = load_wr ? filt_buf_rdata : '0;
    assign filt_ready       = (state == IDLE);
    assign filt_done        = (state == DONE);

endmodule

// File: tb/tb_filt_scratch_loader.sv
// tb/tb_filt_scratch_loader.sv - randomized self-checking bench for filt_scratch_loader
module tb_filt_scratch_loader;

    localparam int AL    = 6;
    localparam int DEPTH = 32;
    localparam int SW    = 8;
    localparam int MFW   = 4;

`ifdef FILT_LOAD_ZERO_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AL-1:0]  filt_len;
    logic [MFW-1:0] max_filt;
    logic           filt_buf_empty;
    logic [SW-1:0]  filt_buf_rdata;
    logic           filt_buf_read;
    logic           filt_scratch_wen;
    logic [AL-1:0]  filt_waddr;
    logic [SW-1:0]  filt_wdata;
    logic           filt_ready;
    logic           filt_done;
    logic [MFW-1:0] filt_count;
    logic           filt_err;

    filt_scratch_loader #(
        .ADDR_LEN     (AL),
        .SCRATCH_DEPTH(DEPTH),
        .SCRATCH_WIDTH(SW),
        .MAX_FILT_W   (MFW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .filt_len        (filt_len),
        .max_filt        (max_filt),
        .filt_buf_empty  (filt_buf_empty),
        .filt_buf_rdata  (filt_buf_rdata),
        .filt_buf_read   (filt_buf_read),
        .filt_scratch_wen(filt_scratch_wen),
        .filt_waddr      (filt_waddr),
        .filt_wdata      (filt_wdata),
        .filt_ready      (filt_ready),
        .filt_done       (filt_done),
        .filt_count      (filt_count),
        .filt_err        (filt_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks   = 0;
    int            failures = 0;
    logic [SW-1:0] fifo_q[$];
    logic [SW-1:0] exp_q[$];
    int            wr_a[$];
    logic [SW-1:0] wr_d[$];
    int            done_n;
    int            done_cyc;
    int            pop_err;
    int            rd_nowr;
    logic [MFW-1:0] done_count;
    logic          done_err;
    int            mode = 0;
    int            s_cyc;
    bit            tog;
    bit            popped;
    bit            e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // FIFO model and write monitor: observe at negedge, apply pop and new head after posedge.
    initial begin
        filt_buf_empty = 1'b1;
        filt_buf_rdata = '0;
        tog = 1'b0;
        forever begin
            @(negedge clk);
            popped = filt_buf_read;
            if (filt_scratch_wen) begin
                wr_a.push_back(int'(filt_waddr));
                wr_d.push_back(filt_wdata);
            end
            if (filt_buf_read && filt_buf_empty) pop_err++;
            if (filt_buf_read && !filt_scratch_wen) rd_nowr++;
            if (filt_done) begin
                done_n++;
                done_cyc   = cyc;
                done_count = filt_count;
                done_err   = filt_err;
            end
            @(posedge clk);
            #1;
            if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
            tog = ~tog;
            case (mode)
                0:       e = 1'b0;
                1:       e = tog;
                default: e = 1'($urandom_range(0, 1));
            endcase
            if (fifo_q.size() == 0) e = 1'b1;
            filt_buf_empty = e;
            filt_buf_rdata = e ? SW'($urandom) : fifo_q[0];
        end
    end

    task automatic start_load(input int len, input int mx);
        @(posedge clk);
        #2;
        while (fifo_q.size() < 100) fifo_q.push_back(SW'($urandom));
        filt_len = AL'(len);
        max_filt = MFW'(mx);
        start    = 1'b1;
        s_cyc    = cyc;
        @(posedge clk);
        #2;
        start = 1'b0;
        exp_q = fifo_q;
        wr_a.delete();
        wr_d.delete();
        done_n   = 0;
        pop_err  = 0;
        rd_nowr  = 0;
        done_cyc = -1;
    endtask

    task automatic wait_done();
        int lim;
        lim = 0;
        while (done_n == 0 && lim < 400) begin
            @(negedge clk);
            lim++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic verify(input string tag, input int len, input int mx, input bit timed);
        int n, npad, nexp, nchk, obs, exp;
        n = DEPTH / len;
        if (mx != 0 && mx < n) n = mx;
        if (n > 15) n = 15;
        npad = PAD_ON ? DEPTH - n * len : 0;
        nexp = n * len + npad;
        wait_done();
        check({tag, "_done_once"}, done_n, 1);
        check({tag, "_nwrites"}, wr_a.size(), nexp);
        nchk = (wr_a.size() < nexp) ? wr_a.size() : nexp;
        for (int i = 0; i < nchk; i++) begin
            obs = (wr_a[i] << 8) | int'(wr_d[i]);
            exp = (i << 8) | ((i < n * len) ? int'(exp_q[i]) : 0);
            check({tag, "_wr_addr_data"}, obs, exp);
        end
        check({tag, "_count"}, done_count, n);
        check({tag, "_err"}, done_err, 0);
        check({tag, "_pop_empty"}, pop_err, 0);
        check({tag, "_pop_nowrite"}, rd_nowr, 0);
        check({tag, "_ready"}, filt_ready, 1);
        if (timed) check({tag, "_done_lat"}, done_cyc - s_cyc, 2 + nexp);
    endtask

    task automatic verify_err(input string tag);
        wait_done();
        check({tag, "_done_once"}, done_n, 1);
        check({tag, "_done_lat"}, done_cyc - s_cyc, 2);
        check({tag, "_err"}, done_err, 1);
        check({tag, "_nwrites"}, wr_a.size(), 0);
        check({tag, "_count"}, done_count, 0);
        check({tag, "_err_held"}, filt_err, 1);
    endtask

    initial begin
        int lim, rl, rm;
        rst      = 1'b1;
        start    = 1'b0;
        filt_len = '0;
        max_filt = '0;
        #3;
        check("rst_ready", filt_ready, 1);
        check("rst_wen", filt_scratch_wen, 0);
        check("rst_read", filt_buf_read, 0);
        check("rst_done", filt_done, 0);
        check("rst_count", filt_count, 0);
        check("rst_err", filt_err, 0);
        check("rst_waddr", filt_waddr, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        mode = 0; start_load(5, 0);  verify("len5_full", 5, 0, 1'b1);
        mode = 0; start_load(4, 2);  verify("len4_max2", 4, 2, 1'b1);
        mode = 1; start_load(3, 0);  verify("len3_toggle", 3, 0, 1'b0);
        mode = 0; start_load(1, 0);  verify("len1_sat", 1, 0, 1'b1);
        mode = 0; start_load(32, 0); verify("len32", 32, 0, 1'b1);

        mode = 0; start_load(0, 0);  verify_err("len0");
        mode = 0; start_load(33, 0); verify_err("len33");
        mode = 2; start_load(7, 3);  verify("after_err", 7, 3, 1'b0);
        check("err_cleared", filt_err, 0);

        // Abort a load in progress with a fresh start.
        mode = 0;
        start_load(5, 0);
        lim = 0;
        while (wr_a.size() < 7 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check("abort_reached7", wr_a.size() >= 7, 1);
        start_load(6, 0);
        verify("abort_restart", 6, 0, 1'b1);

        // Asynchronous reset in the middle of LOAD.
        mode = 0;
        start_load(4, 0);
        lim = 0;
        while (wr_a.size() < 5 && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check("rstmid_reached5", wr_a.size() >= 5, 1);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_ready", filt_ready, 1);
        check("rstmid_wen", filt_scratch_wen, 0);
        check("rstmid_read", filt_buf_read, 0);
        check("rstmid_count", filt_count, 0);
        check("rstmid_waddr", filt_waddr, 0);
        check("rstmid_done", filt_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("rstmid_idle", filt_ready, 1);

        for (int k = 0; k < 4; k++) begin
            rl   = $urandom_range(1, DEPTH);
            rm   = $urandom_range(0, 15);
            mode = $urandom_range(0, 2);
            start_load(rl, rm);
            verify("rand", rl, rm, mode == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
